// File: rtl/isa_pkg.sv
// Instruction encoding constants and the fixed boot program table.
// Shared by the boot sequencer and the instruction memory top.
package isa_pkg;

  localparam logic [2:0]  ADD = 3'd2;
  localparam logic [2:0]  SUB = 3'd3;
  localparam logic [15:0] NOP = 16'd0;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } boot_st_e;

  function automatic logic [15:0] enc(
    input logic [2:0] op,
    input logic [2:0] rd,
    input logic [2:0] rs,
    input logic [2:0] rt
  );
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] boot_word(
    input logic [31:0] addr
  );
    logic [15:0] w;
    case (addr)
      32'd0:  w = enc(ADD, R0, R1, R2);
      32'd1:  w = enc(SUB, R0, R1, R2);
      32'd2,
      32'd3,
      32'd4,
      32'd5:  w = enc(ADD, R0, R1, R2);
      32'd6:  w = enc(SUB, R0, R1, R2);
      default: w = NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_boot_seq.sv
// Boot sequencer: walks every address once after reset, then hands over.
// Ports: Clock/Resetn in; o_init_we/addr/data write port; o_busy status.
module mem_boot_seq
  import isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit BOOT_EN = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic [DATA_W-1:0] o_init_data,
  output logic              o_busy
);

  boot_st_e          r_state;
  boot_st_e          w_next;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // natural wrap returns the counter to 0 as RUN is entered
      if (r_state == S_INIT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_INIT && r_cnt == {ADDR_W{1'b1}})
      w_next = S_RUN;
  end

  always_comb begin
    o_busy      = (r_state == S_INIT);
    o_init_we   = (r_state == S_INIT);
    o_init_addr = r_cnt;
    o_init_data = '0;
    if (BOOT_EN)
      o_init_data = DATA_W'(boot_word(32'(r_cnt)));
  end

endmodule

// File: rtl/memoria_instrucoes_boot.sv
// Instruction memory with registered read, write port and boot reload.
// Ports: Rd_En/Rd_Address -> Q/Q_Valid; Wren/Wr_Address/Din -> Wr_Ack.
module memoria_instrucoes_boot
  import isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit BOOT_EN = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Rd_Address,
  output logic [DATA_W-1:0] Q,
  output logic              Q_Valid,
  input  logic              Wren,
  input  logic [ADDR_W-1:0] Wr_Address,
  input  logic [DATA_W-1:0] Din,
  output logic              Wr_Ack,
  output logic              Init_Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;
  logic              w_busy;

  logic              w_rd;
  logic              w_wr;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [DATA_W-1:0] w_wd;
  logic              w_bypass;

  mem_boot_seq #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BOOT_EN (BOOT_EN)
  ) u_seq (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_data (w_init_data),
    .o_busy      (w_busy)
  );

  assign Init_Busy = w_busy;

  // port requests are dropped while the sequencer owns the array
  assign w_rd = Rd_En && !w_busy;
  assign w_wr = Wren  && !w_busy;

  assign w_we = w_busy ? w_init_we   : w_wr;
  assign w_wa = w_busy ? w_init_addr : Wr_Address;
  assign w_wd = w_busy ? w_init_data : Din;

  assign w_bypass = w_wr && (Wr_Address == Rd_Address);

  always_ff @(posedge Clock) begin
    if (w_we)
      r_mem[w_wa] <= w_wd;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Q       <= '0;
      Q_Valid <= 1'b0;
      Wr_Ack  <= 1'b0;
    end else begin
      Q_Valid <= w_rd;
      Wr_Ack  <= w_wr;
      if (w_rd)
        Q <= w_bypass ? Din : r_mem[Rd_Address];
    end
  end

endmodule

// File: tb/tb_memoria_instrucoes_boot.sv
// Random + directed bench for memoria_instrucoes_boot, two configurations.
// Each cycle both instances are compared against a behavioural model.
module tb_memoria_instrucoes_boot;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn;

  logic        rd0, wr0, qv0, ack0, busy0;
  logic [3:0]  ra0, wa0;
  logic [15:0] d0, q0;

  logic        rd1, wr1, qv1, ack1, busy1;
  logic [5:0]  ra1, wa1;
  logic [31:0] d1, q1;

  memoria_instrucoes_boot #(
    .DATA_W (16), .ADDR_W (4), .BOOT_EN (1'b1)
  ) u_dut0 (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Rd_En      (rd0),
    .Rd_Address (ra0),
    .Q          (q0),
    .Q_Valid    (qv0),
    .Wren       (wr0),
    .Wr_Address (wa0),
    .Din        (d0),
    .Wr_Ack     (ack0),
    .Init_Busy  (busy0)
  );

  memoria_instrucoes_boot #(
    .DATA_W (32), .ADDR_W (6), .BOOT_EN (1'b0)
  ) u_dut1 (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Rd_En      (rd1),
    .Rd_Address (ra1),
    .Q          (q1),
    .Q_Valid    (qv1),
    .Wren       (wr1),
    .Wr_Address (wa1),
    .Din        (d1),
    .Wr_Ack     (ack1),
    .Init_Busy  (busy1)
  );

  logic [31:0] m0 [16];
  logic [31:0] m1 [64];
  int          left0, left1;
  logic [31:0] eq0, eq1;
  logic        eqv0, eqv1, eack0, eack1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] boot_ref(input int a);
    if (a == 1 || a == 6) return 32'h60A0;
    if (a < 7)            return 32'h40A0;
    return 32'h0;
  endfunction

  task automatic model_reset();
    eq0 = '0; eqv0 = 1'b0; eack0 = 1'b0; left0 = 16;
    eq1 = '0; eqv1 = 1'b0; eack1 = 1'b0; left1 = 64;
  endtask

  task automatic model_edge();
    if (left0 > 0) begin
      m0[16-left0] = boot_ref(16 - left0);
      left0--;
      eqv0 = 1'b0; eack0 = 1'b0;
    end else begin
      if (rd0)
        eq0 = (wr0 && wa0 == ra0) ? 32'(d0) : m0[ra0];
      eqv0 = rd0;
      if (wr0) m0[wa0] = 32'(d0);
      eack0 = wr0;
    end
    if (left1 > 0) begin
      m1[64-left1] = 32'h0;
      left1--;
      eqv1 = 1'b0; eack1 = 1'b0;
    end else begin
      if (rd1)
        eq1 = (wr1 && wa1 == ra1) ? d1 : m1[ra1];
      eqv1 = rd1;
      if (wr1) m1[wa1] = d1;
      eack1 = wr1;
    end
  endtask

  task automatic check_all();
    chk("q0",    32'(q0),    eq0);
    chk("qv0",   32'(qv0),   32'(eqv0));
    chk("ack0",  32'(ack0),  32'(eack0));
    chk("busy0", 32'(busy0), 32'(left0 > 0));
    chk("q1",    q1,         eq1);
    chk("qv1",   32'(qv1),   32'(eqv1));
    chk("ack1",  32'(ack1),  32'(eack1));
    chk("busy1", 32'(busy1), 32'(left1 > 0));
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rnd0();
    rd0 = 1'($urandom);
    wr0 = 1'($urandom);
    ra0 = 4'($urandom);
    wa0 = 4'($urandom);
    d0  = 16'($urandom);
  endtask

  task automatic rnd1(input bit allow_wr);
    rd1 = 1'($urandom);
    wr1 = allow_wr ? 1'($urandom) : 1'b0;
    ra1 = 6'($urandom);
    wa1 = 6'($urandom);
    d1  = $urandom;
  endtask

  initial begin
    Resetn = 1'b0;
    rd0 = 0; wr0 = 0; ra0 = 0; wa0 = 0; d0 = 0;
    rd1 = 0; wr1 = 0; ra1 = 0; wa1 = 0; d1 = 0;
    model_reset();
    #12;
    check_all();
    Resetn = 1'b1;

    // requests during INIT must be ignored
    repeat (16) begin rnd0(); rnd1(1'b1); tick(); end

    for (int i = 0; i < 8; i++) begin
      rd0 = 1'b1; ra0 = 4'(i); wr0 = 1'b0;
      rnd1(1'b0);
      tick();
    end

    rd0 = 1'b1; ra0 = 4'd9; wr0 = 1'b1; wa0 = 4'd9; d0 = 16'hBEEF;
    tick();
    rd0 = 1'b1; ra0 = 4'd0; wr0 = 1'b1; wa0 = 4'd3; d0 = 16'($urandom);
    tick();

    repeat (40) begin rnd0(); rnd1(1'b0); tick(); end

    for (int i = 0; i < 64; i++) begin
      rd1 = 1'b1; ra1 = 6'(i); wr1 = 1'b0;
      rnd0();
      tick();
    end

    rd1 = 1'b1; ra1 = 6'd63; wr1 = 1'b1; wa1 = 6'd63; d1 = $urandom;
    tick();
    rd1 = 1'b0; wr1 = 1'b0;
    repeat (3) begin rnd0(); tick(); end
    rd1 = 1'b1; ra1 = 6'd63;
    tick();

    repeat (150) begin rnd0(); rnd1(1'b1); tick(); end

    // leave nonzero outputs so the async clear is observable
    rd0 = 1'b0; wr0 = 1'b1; wa0 = 4'd0; d0 = 16'hA5A5;
    rd1 = 1'b0; wr1 = 1'b1; wa1 = 6'd1; d1 = 32'h1234_5678;
    tick();
    rd0 = 1'b1; ra0 = 4'd0; wr0 = 1'b1; wa0 = 4'd9;
    rd1 = 1'b1; ra1 = 6'd1; wr1 = 1'b1; wa1 = 6'd2;
    tick();

    Resetn = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;

    repeat (16) begin rnd0(); rnd1(1'b1); tick(); end
    rd0 = 1'b1; ra0 = 4'd9; wr0 = 1'b0;
    tick();
    repeat (60) begin rnd0(); rnd1(1'b1); tick(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
